// File: rtl/forwarded_count_rate_pkg.sv
// Shared definitions for the forwarded-counter rate monitor and its periodic tick helper.
package forwarded_count_rate_pkg;

  typedef enum logic [1:0] {
    RATE_STATE_IDLE  = 2'd0,
    RATE_STATE_PRIME = 2'd1,
    RATE_STATE_RUN   = 2'd2
  } rate_state_t;

  // One-second measurement interval on the 100 MHz system clock.
  localparam int unsigned DEFAULT_INTERVAL_TICKS = 100_000_000;

endpackage

// File: rtl/forwarded_count_rate_interval_tick.sv
// Periodic down-counter that strobes tick for one cycle every TICKS cycles; hold parks it at reload.
module interval_tick
  import forwarded_count_rate_pkg::*;
#(
  parameter int unsigned TICKS = DEFAULT_INTERVAL_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICKS);
  localparam logic [CW-1:0] RELOAD = CW'(TICKS - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || hold) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/forwarded_count_rate.sv
// Per-interval increment of a forwarded free-running counter, with wrap, saturation and stall reporting.
module forwarded_count_rate
  import forwarded_count_rate_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned RATE_WIDTH     = 32,
  parameter int unsigned INTERVAL_TICKS = DEFAULT_INTERVAL_TICKS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] countIn,
  output logic [RATE_WIDTH-1:0]  rate,
  output logic                   rateValid,
  output logic                   rateSaturated,
  output logic                   stalled,
  output logic [15:0]            intervalCount
);

  rate_state_t            state;
  logic                   tick;
  logic                   idle;
  logic [COUNT_WIDTH-1:0] prev_count;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   change_seen;
  logic                   changed;
  logic [COUNT_WIDTH-1:0] delta;
  logic                   saturated;

  assign idle      = (state == RATE_STATE_IDLE);
  assign changed   = (countIn != count_d);
  // Unsigned modular subtraction absorbs a single wrap of the source counter.
  assign delta     = countIn - prev_count;
  assign saturated = ((delta >> RATE_WIDTH) != '0);

  interval_tick #(
    .TICKS(INTERVAL_TICKS)
  ) u_interval_tick (
    .clk  (clk),
    .reset(reset),
    .hold (idle),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RATE_STATE_IDLE;
      prev_count    <= '0;
      count_d       <= '0;
      change_seen   <= 1'b0;
      rate          <= '0;
      rateValid     <= 1'b0;
      rateSaturated <= 1'b0;
      stalled       <= 1'b0;
      intervalCount <= '0;
    end else begin
      count_d   <= countIn;
      rateValid <= 1'b0;

      // A change landing on the tick cycle belongs to the interval that starts there.
      if (tick) begin
        change_seen <= changed;
      end else if (changed) begin
        change_seen <= 1'b1;
      end

      if (!enable) begin
        state <= RATE_STATE_IDLE;
      end else begin
        case (state)
          RATE_STATE_IDLE: state <= RATE_STATE_PRIME;
          RATE_STATE_PRIME: begin
            if (tick) begin
              prev_count <= countIn;
              state      <= RATE_STATE_RUN;
            end
          end
          RATE_STATE_RUN: begin
            if (tick) begin
              prev_count    <= countIn;
              rate          <= saturated ? '1 : delta[RATE_WIDTH-1:0];
              rateSaturated <= saturated;
              stalled       <= !change_seen;
              rateValid     <= 1'b1;
              intervalCount <= intervalCount + 16'd1;
            end
          end
          default: state <= RATE_STATE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_forwarded_count_rate.sv
// Randomized bench comparing two rate monitors (32-bit and 8-bit rate) against an interval-level model.
module tb_forwarded_count_rate;

  localparam int TICKS = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] count_in;

  logic [31:0] r32;
  logic        v32, s32, st32;
  logic [15:0] ic32;
  logic [7:0]  r8;
  logic        v8, s8, st8;
  logic [15:0] ic8;

  always #5 clk = ~clk;

  forwarded_count_rate #(.COUNT_WIDTH(32), .RATE_WIDTH(32), .INTERVAL_TICKS(TICKS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .countIn(count_in),
    .rate(r32), .rateValid(v32), .rateSaturated(s32), .stalled(st32), .intervalCount(ic32)
  );

  forwarded_count_rate #(.COUNT_WIDTH(32), .RATE_WIDTH(8), .INTERVAL_TICKS(TICKS)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .countIn(count_in),
    .rate(r8), .rateValid(v8), .rateSaturated(s8), .stalled(st8), .intervalCount(ic8)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: countIn samples indexed by clock edge; a measurement sequence starts at
  // the first enabled edge s, samples at s+10k, and publishes from the second sample onward.
  logic [31:0] hist[$];
  bit          armed = 0;
  int          s = 0;
  logic        exp_valid = 0, exp_sat32 = 0, exp_sat8 = 0, exp_stalled = 0;
  logic [31:0] exp_rate32 = '0;
  logic [7:0]  exp_rate8 = '0;
  logic [15:0] exp_count = '0;

  task automatic model_update();
    logic [31:0] delta;
    bit          moved;
    int          n;
    hist.push_back(count_in);
    n = hist.size() - 1;
    exp_valid = 0;
    if (reset) begin
      armed = 0;
      exp_rate32 = '0; exp_rate8 = '0; exp_sat32 = 0; exp_sat8 = 0;
      exp_stalled = 0; exp_count = '0;
    end else if (!enable) begin
      armed = 0;
    end else if (!armed) begin
      armed = 1;
      s = n;
    end else if ((n - s) % TICKS == 0 && (n - s) >= 2 * TICKS) begin
      delta = hist[n] - hist[n-TICKS];
      moved = 0;
      for (int j = n - TICKS; j < n; j++) if (hist[j] != hist[j-1]) moved = 1;
      exp_valid   = 1;
      exp_rate32  = delta;
      exp_sat32   = 0;
      exp_sat8    = (delta > 32'd255);
      exp_rate8   = exp_sat8 ? 8'hFF : delta[7:0];
      exp_stalled = !moved;
      exp_count   = exp_count + 16'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("rateValid32", v32, exp_valid);
    check("rate32", r32, exp_rate32);
    check("sat32", s32, exp_sat32);
    check("stalled32", st32, exp_stalled);
    check("count32", ic32, exp_count);
    check("rateValid8", v8, exp_valid);
    check("rate8", r8, exp_rate8);
    check("sat8", s8, exp_sat8);
    check("stalled8", st8, exp_stalled);
    check("count8", ic8, exp_count);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!v32 && cycles < 60);
    check("wait_valid_timeout", v32, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          got;
    logic [31:0] prior;
    int          nvalid;

    reset = 1'b1; enable = 1'b0; count_in = 32'h1000;
    repeat (3) step();
    check("reset_rate", r32, 0);
    check("reset_valid", v32, 0);
    check("reset_count", ic32, 0);

    // First rate: +3 per interval, first strobe 21 edges after release.
    reset = 1'b0; enable = 1'b1;
    got = 0; lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (i % 10 == 5) count_in += 3;
      step();
      if (v32) begin got = 1; lat = i; end
    end
    check("first_latency", lat, 21);
    check("first_rate", r32, 3);
    check("first_sat", s32, 0);
    check("first_stalled", st32, 0);
    check("first_count", ic32, 1);

    // Wrap of the source counter.
    wait_valid(lat);
    count_in = 32'hFFFF_FFF0;
    wait_valid(lat);
    count_in = 32'h0000_0010;
    wait_valid(lat);
    check("wrap_rate32", r32, 32'h20);
    check("wrap_sat32", s32, 0);
    check("wrap_rate8", r8, 8'h20);
    check("wrap_sat8", s8, 0);

    // Delta beyond the 8-bit rate range.
    count_in = 32'h0;
    wait_valid(lat);
    count_in = 32'h1F4;
    wait_valid(lat);
    check("big_rate32", r32, 32'h1F4);
    check("big_rate8", r8, 8'hFF);
    check("big_sat8", s8, 1);

    // Constant interval reports stall, then a single +1.
    wait_valid(lat);
    wait_valid(lat);
    check("stall_rate", r32, 0);
    check("stall_flag", st32, 1);
    repeat (4) step();
    count_in += 1;
    wait_valid(lat);
    check("one_rate", r32, 1);
    check("one_stalled", st32, 0);

    // Three-cycle enable drop mid-RUN forces a fresh PRIME.
    repeat (3) step();
    prior = r32;
    enable = 1'b0;
    repeat (3) begin
      step();
      check("disable_hold_rate", r32, prior);
    end
    enable = 1'b1;
    got = 0; lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      step();
      if (v32) begin got = 1; lat = i; end
      else check("reenable_hold_rate", r32, prior);
    end
    check("reenable_latency", lat, 21);

    // Reset landing on a tick cycle.
    repeat (TICKS - 1) step();
    reset = 1'b1;
    step();
    check("tick_reset_valid", v32, 0);
    check("tick_reset_rate", r32, 0);
    check("tick_reset_count", ic32, 0);
    reset = 1'b0;
    wait_valid(lat);
    check("post_reset_latency", lat, 21);
    check("post_reset_count", ic32, 1);

    // Randomized traffic with occasional enable drops, jumps and resets.
    nvalid = 0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 99) < 98);
      case ($urandom_range(0, 9))
        6, 7: count_in += $urandom_range(1, 20);
        8:    count_in += $urandom_range(200, 400);
        9:    if ($urandom_range(0, 7) == 0) count_in = $urandom;
        default: ;
      endcase
      step();
      if (v32) nvalid++;
    end
    check("random_valids_seen", (nvalid > 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
